// File: rtl/pe_ctrl_pkg.sv
// Shared types and width helpers for the PE sequencer.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PROCESS    = 3'd1,
        ST_ACCUMULATE = 3'd2,
        ST_STRIDE     = 3'd3,
        ST_PADDING    = 3'd4,
        ST_LOAD       = 3'd5
    } state_t;

    // Width needed to hold the full product of two unsigned fields.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/pe_loop_cnt.sv
// Loop counter: counts 0..limit, wraps to 0, carry marks the wrapping step.
module pe_loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         carry
);

    assign wrap  = (cnt == limit);
    assign carry = en & wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/pe_ctrl_mc.sv
// Processing-element sequencer: spad addressing, MAC/psum control, stride,
// padding and multi-pass load for one PE, with start-time config snapshot.
module pe_ctrl_mc
    import pe_ctrl_pkg::*;
#(
    parameter int F_WIDTH           = 6,
    parameter int S_WIDTH           = 4,
    parameter int U_WIDTH           = 3,
    parameter int n_WIDTH           = 3,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int PAD_WIDTH         = 3,
    parameter int IFMAP_ADDR_WIDTH  = 4,
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PSUM_ADDR_WIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         await,
    input  logic                         acc_mode,
    input  logic [S_WIDTH-1:0]           S,
    input  logic [F_WIDTH-1:0]           F,
    input  logic [U_WIDTH-1:0]           U,
    input  logic [n_WIDTH-1:0]           n,
    input  logic [p_WIDTH-1:0]           p,
    input  logic [q_WIDTH-1:0]           q,
    input  logic [PAD_WIDTH-1:0]         pad_cnt,
    input  logic                         ipsum_fifo_empty,
    input  logic                         opsum_fifo_full,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic                         reset_accumulation,
    output logic                         accumulate_ipsum,
    output logic                         opsum_push,
    output logic                         reset_ifmap_spad,
    output logic                         reset_filter_spad,
    output logic                         shift,
    output logic                         rd_data,
    output logic                         wr_psum,
    output logic                         pad,
    output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_addr,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_addr,
    output logic [PSUM_ADDR_WIDTH-1:0]   psum_addr
);

    localparam int SQ_W = prod_w(S_WIDTH, q_WIDTH);
    localparam int UQ_W = prod_w(U_WIDTH, q_WIDTH);
    localparam int IP_W = prod_w(SQ_W, p_WIDTH);

    state_t state, state_nx;

    logic [S_WIDTH-1:0]   s_r;
    logic [F_WIDTH-1:0]   f_r;
    logic [U_WIDTH-1:0]   u_r;
    logic [n_WIDTH-1:0]   n_r;
    logic [p_WIDTH-1:0]   p_r;
    logic [q_WIDTH-1:0]   q_r;
    logic [PAD_WIDTH-1:0] pad_r;
    logic                 acc_r;

    logic [SQ_W-1:0]      i_cnt, i_lim;
    logic [p_WIDTH-1:0]   j_cnt, j_lim;
    logic [F_WIDTH-1:0]   f_cnt, f_lim;
    logic [UQ_W-1:0]      u_cnt, u_lim;
    logic [PAD_WIDTH-1:0] k_cnt, k_lim;
    logic [n_WIDTH-1:0]   m_cnt, m_lim;

    logic i_en, j_en, f_en, u_en, k_en, m_en, cnt_clr;
    logic i_wrap, j_wrap, f_wrap, u_wrap, k_wrap, m_wrap;
    logic i_carry, j_carry, f_carry, u_carry, k_carry, m_carry;
    logic cfg_bad, acc_ok, proc_go, acc_go;
    logic unused_wraps;

    assign cfg_bad = (S == '0) | (F == '0) | (U == '0) |
                     (n == '0) | (p == '0) | (q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            s_r   <= '0;
            f_r   <= '0;
            u_r   <= '0;
            n_r   <= '0;
            p_r   <= '0;
            q_r   <= '0;
            pad_r <= '0;
            acc_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start && !cfg_bad) begin
                s_r   <= S;
                f_r   <= F;
                u_r   <= U;
                n_r   <= n;
                p_r   <= p;
                q_r   <= q;
                pad_r <= pad_cnt;
                acc_r <= acc_mode;
            end
        end
    end

    // Loop limits are last values; products are formed at full width first.
    assign i_lim = SQ_W'(s_r) * SQ_W'(q_r) - SQ_W'(1);
    assign j_lim = p_r - p_WIDTH'(1);
    assign f_lim = f_r - F_WIDTH'(1);
    assign u_lim = UQ_W'(u_r) * UQ_W'(q_r) - UQ_W'(1);
    assign k_lim = pad_r - PAD_WIDTH'(1);
    assign m_lim = n_r - n_WIDTH'(1);

    assign acc_ok  = acc_r ? (~ipsum_fifo_empty & ~opsum_fifo_full) : ~opsum_fifo_full;
    assign proc_go = (state == ST_PROCESS) & ~abort & ~await;
    assign acc_go  = (state == ST_ACCUMULATE) & ~abort & acc_ok;
    assign cnt_clr = (state == ST_IDLE) | abort;

    assign j_en = proc_go | acc_go;
    assign i_en = j_carry & (state == ST_PROCESS);
    assign f_en = j_carry & (state == ST_ACCUMULATE);
    assign u_en = (state == ST_STRIDE) & ~abort;
    assign k_en = (state == ST_PADDING) & ~abort;
    assign m_en = (state == ST_LOAD) & ~abort;

    pe_loop_cnt #(.W(SQ_W)) u_i_cnt (
        .clk(clk), .reset(reset), .en(i_en), .clr(cnt_clr), .limit(i_lim),
        .cnt(i_cnt), .wrap(i_wrap), .carry(i_carry));
    pe_loop_cnt #(.W(p_WIDTH)) u_j_cnt (
        .clk(clk), .reset(reset), .en(j_en), .clr(cnt_clr), .limit(j_lim),
        .cnt(j_cnt), .wrap(j_wrap), .carry(j_carry));
    pe_loop_cnt #(.W(F_WIDTH)) u_f_cnt (
        .clk(clk), .reset(reset), .en(f_en), .clr(cnt_clr), .limit(f_lim),
        .cnt(f_cnt), .wrap(f_wrap), .carry(f_carry));
    pe_loop_cnt #(.W(UQ_W)) u_u_cnt (
        .clk(clk), .reset(reset), .en(u_en), .clr(cnt_clr), .limit(u_lim),
        .cnt(u_cnt), .wrap(u_wrap), .carry(u_carry));
    pe_loop_cnt #(.W(PAD_WIDTH)) u_k_cnt (
        .clk(clk), .reset(reset), .en(k_en), .clr(cnt_clr), .limit(k_lim),
        .cnt(k_cnt), .wrap(k_wrap), .carry(k_carry));
    pe_loop_cnt #(.W(n_WIDTH)) u_m_cnt (
        .clk(clk), .reset(reset), .en(m_en), .clr(cnt_clr), .limit(m_lim),
        .cnt(m_cnt), .wrap(m_wrap), .carry(m_carry));

    // Transitions key off carries; the level wrap flags are not needed here.
    assign unused_wraps = &{1'b0, i_wrap, j_wrap, f_wrap, u_wrap, k_wrap, m_wrap,
                            f_cnt, u_cnt, k_cnt, m_cnt};

    assign busy        = (state != ST_IDLE);
    assign ifmap_addr  = IFMAP_ADDR_WIDTH'(i_cnt);
    assign psum_addr   = PSUM_ADDR_WIDTH'(j_cnt);
    assign filter_addr = FILTER_ADDR_WIDTH'(IP_W'(i_cnt) * IP_W'(p_r) + IP_W'(j_cnt));

    always_comb begin
        state_nx           = state;
        cfg_err            = 1'b0;
        done               = 1'b0;
        reset_accumulation = 1'b0;
        accumulate_ipsum   = 1'b0;
        opsum_push         = 1'b0;
        reset_ifmap_spad   = 1'b0;
        reset_filter_spad  = 1'b0;
        shift              = 1'b0;
        rd_data            = 1'b0;
        wr_psum            = 1'b0;
        pad                = 1'b0;
        if (state != ST_IDLE && abort) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) cfg_err = reset;
                        else         state_nx = ST_PROCESS;
                    end
                end
                ST_PROCESS: begin
                    if (proc_go) begin
                        rd_data            = 1'b1;
                        wr_psum            = 1'b1;
                        reset_accumulation = (i_cnt == '0);
                        if (i_carry) state_nx = ST_ACCUMULATE;
                    end
                end
                ST_ACCUMULATE: begin
                    if (acc_go) begin
                        opsum_push       = 1'b1;
                        accumulate_ipsum = acc_r;
                        if (j_carry) begin
                            if (!f_carry)          state_nx = ST_STRIDE;
                            else if (pad_r != '0)  state_nx = ST_PADDING;
                            else                   state_nx = ST_LOAD;
                        end
                    end
                end
                ST_STRIDE: begin
                    shift = 1'b1;
                    if (u_carry) state_nx = ST_PROCESS;
                end
                ST_PADDING: begin
                    pad = 1'b1;
                    if (k_carry) state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    reset_ifmap_spad = 1'b1;
                    if (m_carry) begin
                        reset_filter_spad = 1'b1;
                        done              = 1'b1;
                        state_nx          = ST_IDLE;
                    end else begin
                        state_nx = ST_PROCESS;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctrl_mc.sv
// Directed bench for pe_ctrl_mc: job table plus stall/block/abort/reset sequences.
module tb_pe_ctrl_mc;

    logic       clk = 1'b0;
    logic       reset, start, abort, await, acc_mode;
    logic [3:0] S;
    logic [5:0] F;
    logic [2:0] U, n;
    logic [4:0] p;
    logic [2:0] q, pad_cnt;
    logic       ipsum_fifo_empty, opsum_fifo_full;
    logic       busy, done, cfg_err, reset_accumulation, accumulate_ipsum, opsum_push;
    logic       reset_ifmap_spad, reset_filter_spad, shift, rd_data, wr_psum, pad;
    logic [3:0] ifmap_addr;
    logic [7:0] filter_addr;
    logic [4:0] psum_addr;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pe_ctrl_mc dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .await(await),
        .acc_mode(acc_mode), .S(S), .F(F), .U(U), .n(n), .p(p), .q(q),
        .pad_cnt(pad_cnt), .ipsum_fifo_empty(ipsum_fifo_empty),
        .opsum_fifo_full(opsum_fifo_full), .busy(busy), .done(done),
        .cfg_err(cfg_err), .reset_accumulation(reset_accumulation),
        .accumulate_ipsum(accumulate_ipsum), .opsum_push(opsum_push),
        .reset_ifmap_spad(reset_ifmap_spad), .reset_filter_spad(reset_filter_spad),
        .shift(shift), .rd_data(rd_data), .wr_psum(wr_psum), .pad(pad),
        .ifmap_addr(ifmap_addr), .filter_addr(filter_addr), .psum_addr(psum_addr)
    );

    typedef struct {
        logic [3:0] s;
        logic [5:0] f;
        logic [2:0] u, nn;
        logic [4:0] pp;
        logic [2:0] qq, pd;
        logic       acc, empty;
        int cyc, rd, racc, push, aip, shf, pdn, rif, rfs;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input vec_t v);
        @(posedge clk); #1;
        S = v.s; F = v.f; U = v.u; n = v.nn; p = v.pp; q = v.qq; pad_cnt = v.pd;
        acc_mode = v.acc; ipsum_fifo_empty = v.empty;
        opsum_fifo_full = 1'b0; await = 1'b0; abort = 1'b0; start = 1'b1;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic vec_t mk(input int s, input int f, input int u, input int nn,
                                input int pp, input int qq, input int pd, input int acc,
                                input int empty, input int cyc, input int rd, input int racc,
                                input int push, input int aip, input int shf, input int pdn,
                                input int rif, input int rfs);
        vec_t v;
        v.s = 4'(s); v.f = 6'(f); v.u = 3'(u); v.nn = 3'(nn); v.pp = 5'(pp);
        v.qq = 3'(qq); v.pd = 3'(pd); v.acc = 1'(acc); v.empty = 1'(empty);
        v.cyc = cyc; v.rd = rd; v.racc = racc; v.push = push; v.aip = aip;
        v.shf = shf; v.pdn = pdn; v.rif = rif; v.rfs = rfs;
        return v;
    endfunction

    initial begin
        int c, first_push, done_at, blocked_strobes, stall_rd, na;
        int cnt_rd, cnt_racc, cnt_push, cnt_aip, cnt_shf, cnt_pad, cnt_rif, cnt_rfs, cnt_busy;
        int addrs[6];

        vecs[0] = mk(3, 2, 1, 1, 2, 1, 0, 1, 0, 18, 12, 4, 4, 4, 1, 0, 1, 1);
        vecs[1] = mk(3, 2, 1, 2, 2, 1, 3, 1, 0, 42, 24, 8, 8, 8, 2, 6, 2, 1);
        vecs[2] = mk(2, 1, 2, 1, 3, 2, 1, 0, 1, 17, 12, 3, 3, 0, 0, 1, 1, 1);
        vecs[3] = mk(1, 3, 2, 1, 1, 2, 0, 1, 0, 18, 6, 3, 3, 3, 8, 0, 1, 1);

        reset = 1'b0; start = 1'b0; abort = 1'b0; await = 1'b0; acc_mode = 1'b0;
        S = '0; F = '0; U = '0; n = '0; p = '0; q = '0; pad_cnt = '0;
        ipsum_fifo_empty = 1'b0; opsum_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_strobes", {done, cfg_err, rd_data, opsum_push, shift, pad}, 0);
        check("reset_addr", {ifmap_addr, filter_addr, psum_addr}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Rejected start
        launch(mk(3, 2, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        next_cycle(); @(negedge clk);
        check("cfg_err_once", cfg_err, 0);
        check("cfg_err_idle", busy, 0);

        // Abort during STRIDE (job cycle 9)
        launch(vecs[0]);
        for (c = 1; c <= 9; c++) begin
            next_cycle();
            abort = (c == 9);
            @(negedge clk);
        end
        check("abort_shift_low", shift, 0);
        check("abort_no_done", done, 0);
        next_cycle(); abort = 1'b0; @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_done", {done, reset_filter_spad, reset_ifmap_spad}, 0);

        // Job table
        foreach (vecs[vi]) begin
            launch(vecs[vi]);
            cnt_rd = 0; cnt_racc = 0; cnt_push = 0; cnt_aip = 0; cnt_shf = 0;
            cnt_pad = 0; cnt_rif = 0; cnt_rfs = 0; cnt_busy = 0; done_at = 0;
            for (c = 1; c <= 400 && done_at == 0; c++) begin
                next_cycle(); @(negedge clk);
                if (c == 1) begin
                    check($sformatf("v%0d_first_faddr", vi), filter_addr, 0);
                    check($sformatf("v%0d_first_racc", vi), reset_accumulation, 1);
                end
                cnt_rd += rd_data; cnt_racc += reset_accumulation; cnt_push += opsum_push;
                cnt_aip += accumulate_ipsum; cnt_shf += shift; cnt_pad += pad;
                cnt_rif += reset_ifmap_spad; cnt_rfs += reset_filter_spad; cnt_busy += busy;
                if (done) begin
                    done_at = c;
                    check($sformatf("v%0d_rfs_with_done", vi), reset_filter_spad, 1);
                end
            end
            check($sformatf("v%0d_done_cycle", vi), done_at, vecs[vi].cyc);
            check($sformatf("v%0d_busy_cycles", vi), cnt_busy, vecs[vi].cyc);
            check($sformatf("v%0d_rd_data", vi), cnt_rd, vecs[vi].rd);
            check($sformatf("v%0d_reset_acc", vi), cnt_racc, vecs[vi].racc);
            check($sformatf("v%0d_opsum_push", vi), cnt_push, vecs[vi].push);
            check($sformatf("v%0d_acc_ipsum", vi), cnt_aip, vecs[vi].aip);
            check($sformatf("v%0d_shift", vi), cnt_shf, vecs[vi].shf);
            check($sformatf("v%0d_pad", vi), cnt_pad, vecs[vi].pdn);
            check($sformatf("v%0d_rst_ifmap", vi), cnt_rif, vecs[vi].rif);
            check($sformatf("v%0d_rst_filter", vi), cnt_rfs, vecs[vi].rfs);
            next_cycle(); @(negedge clk);
            check($sformatf("v%0d_idle_after", vi), busy, 0);
        end

        // Stall on await for PROCESS cycles 2-4
        launch(vecs[0]);
        first_push = 0; done_at = 0; stall_rd = 0; na = 0;
        for (c = 1; c <= 400 && done_at == 0; c++) begin
            next_cycle();
            await = (c >= 2 && c <= 4);
            @(negedge clk);
            if (await) stall_rd += rd_data + wr_psum + reset_accumulation;
            if (rd_data && na < 6) begin addrs[na] = filter_addr; na++; end
            if (opsum_push && first_push == 0) first_push = c;
            if (done) done_at = c;
        end
        await = 1'b0;
        check("stall_strobes", stall_rd, 0);
        check("stall_first_push", first_push, 10);
        check("stall_done_cycle", done_at, 21);
        for (int a = 0; a < 6; a++) check($sformatf("stall_faddr%0d", a), addrs[a], a);

        // Output FIFO full for the first 5 ACCUMULATE cycles
        launch(vecs[0]);
        first_push = 0; done_at = 0; blocked_strobes = 0;
        for (c = 1; c <= 400 && done_at == 0; c++) begin
            next_cycle();
            opsum_fifo_full = (c >= 7 && c <= 11);
            @(negedge clk);
            if (opsum_fifo_full) blocked_strobes += opsum_push + accumulate_ipsum + busy * 0 + (psum_addr != 0);
            if (opsum_push && first_push == 0) begin
                first_push = c;
                check("full_first_psum_addr", psum_addr, 0);
            end
            if (done) done_at = c;
        end
        opsum_fifo_full = 1'b0;
        check("full_blocked_strobes", blocked_strobes, 0);
        check("full_first_push", first_push, 12);
        check("full_done_cycle", done_at, 23);

        // Asynchronous reset mid-ACCUMULATE (job cycle 8: j=1, pushing)
        launch(vecs[0]);
        for (c = 1; c <= 8; c++) begin
            next_cycle(); @(negedge clk);
        end
        check("pre_reset_push", opsum_push, 1);
        check("pre_reset_psum_addr", psum_addr, 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_strobes", {opsum_push, accumulate_ipsum, done, rd_data}, 0);
        check("async_reset_addr", {ifmap_addr, filter_addr, psum_addr}, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
